// File: rtl/mult_pkg.sv
// Shared definitions for the sequential shift-add multiplier.
package mult_pkg;

    localparam int DEFAULT_WIDTH = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/add_gate_stage.sv
// One gated-adder row: {cout, s} = acc + (gate ? a : 0).
module add_gate_stage #(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] acc,
    input  logic [WIDTH-1:0] a,
    input  logic             gate,
    output logic [WIDTH-1:0] s,
    output logic             cout
);

    logic [WIDTH-1:0] addend;

    always_comb begin
        addend    = gate ? a : '0;
        {cout, s} = {1'b0, acc} + {1'b0, addend};
    end

endmodule

// File: rtl/mult_seq_ctrl.sv
// Sequential unsigned multiplier: one gated-adder stage reused for WIDTH cycles
// behind a start/busy/done handshake.
module mult_seq_ctrl
    import mult_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   product
);

    state_t             state;
    state_t             state_nxt;
    logic               accept;
    logic               last_step;

    logic [WIDTH-1:0]   mcand;
    logic [WIDTH-1:0]   acc_hi;
    logic [WIDTH-1:0]   mq;
    logic [CNT_W-1:0]   cnt;

    logic [WIDTH-1:0]   sum;
    logic               carry;

    add_gate_stage #(.WIDTH(WIDTH)) u_stage (
        .acc  (acc_hi),
        .a    (mcand),
        .gate (mq[0]),
        .s    (sum),
        .cout (carry)
    );

    assign last_step = (cnt == CNT_W'(WIDTH - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        done      = 1'b0;
        accept    = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    accept    = 1'b1;
                    state_nxt = ST_RUN;
                end
            end
            ST_RUN: begin
                busy = 1'b1;
                if (last_step) begin
                    state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                done = 1'b1;
                if (start) begin
                    accept    = 1'b1;
                    state_nxt = ST_RUN;
                end else begin
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Each RUN edge shifts {carry, sum, mq} right by one; the final step's
    // shifted value is captured straight into product.
    always_ff @(posedge clk) begin
        if (rst) begin
            mcand   <= '0;
            acc_hi  <= '0;
            mq      <= '0;
            cnt     <= '0;
            product <= '0;
        end else if (accept) begin
            mcand  <= a;
            mq     <= b;
            acc_hi <= '0;
            cnt    <= '0;
        end else if (state == ST_RUN) begin
            acc_hi <= {carry, sum[WIDTH-1:1]};
            mq     <= {sum[0], mq[WIDTH-1:1]};
            cnt    <= cnt + CNT_W'(1);
            if (last_step) begin
                product <= {carry, sum, mq[WIDTH-1:1]};
            end
        end
    end

endmodule

// File: tb/tb_mult_seq_ctrl.sv
// Randomized and directed bench for mult_seq_ctrl against an arithmetic reference.
module tb_mult_seq_ctrl;

    localparam int W = 4;

    logic           clk;
    logic           rst;
    logic           start;
    logic [W-1:0]   a;
    logic [W-1:0]   b;
    logic           busy;
    logic           done;
    logic [2*W-1:0] product;

    int passed = 0;
    int total  = 0;

    mult_seq_ctrl #(.WIDTH(W)) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .a       (a),
        .b       (b),
        .busy    (busy),
        .done    (done),
        .product (product)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [2*W-1:0] ref_mul(input int unsigned x, input int unsigned y);
        int unsigned p;
        p = x * y;
        return p[2*W-1:0];
    endfunction

    // Launches one operation and watches it to completion (bounded).
    // lat = negedge index at which done was seen (0 on timeout).
    task automatic run_op(input logic [W-1:0] ia, input logic [W-1:0] ib,
                          output int lat, output int bcnt, output logic [2*W-1:0] prod);
        @(negedge clk);
        a = ia; b = ib; start = 1'b1;
        @(posedge clk);
        lat = 0; bcnt = 0; prod = '0;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (i == 1) start = 1'b0;
            if (done) begin
                lat  = i;
                prod = product;
                break;
            end
            if (busy) bcnt++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b1; a = 4'd9; b = 4'd6;
        repeat (2) begin
            @(negedge clk);
            total++;
            if (busy !== 1'b0 || done !== 1'b0 || product !== 8'h00) begin
                $display("FAIL reset_state busy=%b done=%b product=%h required 0 0 00", busy, done, product);
            end else passed++;
        end
        rst = 1'b0; start = 1'b0;
        @(negedge clk);
        total++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            $display("FAIL reset_no_accept busy=%b done=%b required 0 0", busy, done);
        end else passed++;
    endtask

    task automatic test_basic();
        int lat, bcnt;
        logic [2*W-1:0] p;
        run_op(4'd9, 4'd6, lat, bcnt, p);
        total++;
        if (lat !== W + 1 || bcnt !== W) begin
            $display("FAIL basic_timing lat=%0d busy_cycles=%0d required %0d %0d", lat, bcnt, W + 1, W);
        end else passed++;
        total++;
        if (p !== ref_mul(9, 6)) begin
            $display("FAIL basic_product got=%h required %h", p, ref_mul(9, 6));
        end else passed++;
        @(negedge clk);
        total++;
        if (done !== 1'b0 || product !== ref_mul(9, 6)) begin
            $display("FAIL basic_hold done=%b product=%h required 0 %h", done, product, ref_mul(9, 6));
        end else passed++;
    endtask

    task automatic test_corners();
        logic [W-1:0] ca [5] = '{4'd15, 4'd0,  4'd13, 4'd1,  4'd15};
        logic [W-1:0] cb [5] = '{4'd15, 4'd13, 4'd0,  4'd15, 4'd1};
        int lat, bcnt;
        logic [2*W-1:0] p;
        for (int i = 0; i < 5; i++) begin
            run_op(ca[i], cb[i], lat, bcnt, p);
            total++;
            if (lat !== W + 1 || p !== ref_mul(ca[i], cb[i])) begin
                $display("FAIL corner_%0d a=%0d b=%0d lat=%0d product=%h required lat=%0d product=%h",
                         i, ca[i], cb[i], lat, p, W + 1, ref_mul(ca[i], cb[i]));
            end else passed++;
        end
    endtask

    task automatic test_random();
        int lat, bcnt;
        logic [2*W-1:0] p;
        logic [W-1:0] ra, rb;
        for (int i = 0; i < 24; i++) begin
            ra = W'($urandom_range(0, 2**W - 1));
            rb = W'($urandom_range(0, 2**W - 1));
            repeat ($urandom_range(0, 2)) @(negedge clk);
            run_op(ra, rb, lat, bcnt, p);
            total++;
            if (lat !== W + 1 || p !== ref_mul(ra, rb)) begin
                $display("FAIL random_%0d a=%0d b=%0d lat=%0d product=%h required lat=%0d product=%h",
                         i, ra, rb, lat, p, W + 1, ref_mul(ra, rb));
            end else passed++;
        end
    endtask

    task automatic test_busy_protect();
        int dones = 0, first = 0;
        logic [2*W-1:0] p = '0;
        @(negedge clk);
        a = 4'd3; b = 4'd5; start = 1'b1;
        @(posedge clk);
        for (int i = 1; i <= 12; i++) begin
            @(negedge clk);
            if (done) begin
                dones++;
                if (first == 0) begin first = i; p = product; end
            end
            if (i >= 2 && i <= 4) begin
                start = 1'b1; a = 4'd7; b = 4'd7;
            end else begin
                start = 1'b0;
            end
        end
        total++;
        if (dones !== 1 || first !== W + 1 || p !== ref_mul(3, 5)) begin
            $display("FAIL busy_protect dones=%0d lat=%0d product=%h required 1 %0d %h",
                     dones, first, p, W + 1, ref_mul(3, 5));
        end else passed++;
    endtask

    task automatic test_back_to_back();
        int d1 = 0, d2 = 0;
        logic busy_after = 1'b0;
        logic [2*W-1:0] p1 = '0, p2 = '0;
        @(negedge clk);
        a = 4'd2; b = 4'd3; start = 1'b1;
        @(posedge clk);
        for (int i = 1; i <= 30; i++) begin
            @(negedge clk);
            if (d1 > 0 && i == d1 + 1) busy_after = busy;
            if (done) begin
                if (d1 == 0) begin
                    d1 = i; p1 = product; a = 4'd4; b = 4'd4;
                end else begin
                    d2 = i; p2 = product; start = 1'b0;
                    break;
                end
            end
        end
        start = 1'b0;
        total++;
        if (d1 !== W + 1 || d2 - d1 !== W + 1) begin
            $display("FAIL b2b_timing first=%0d gap=%0d required %0d %0d", d1, d2 - d1, W + 1, W + 1);
        end else passed++;
        total++;
        if (p1 !== ref_mul(2, 3) || p2 !== ref_mul(4, 4)) begin
            $display("FAIL b2b_products got=%h,%h required %h,%h", p1, p2, ref_mul(2, 3), ref_mul(4, 4));
        end else passed++;
        total++;
        if (busy_after !== 1'b1) begin
            $display("FAIL b2b_no_idle busy=%b required 1", busy_after);
        end else passed++;
    endtask

    task automatic test_reset_mid();
        int dones = 0, lat, bcnt;
        logic [2*W-1:0] p;
        @(negedge clk);
        a = 4'd15; b = 4'd15; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        total++;
        if (busy !== 1'b0 || done !== 1'b0 || product !== 8'h00) begin
            $display("FAIL reset_mid busy=%b done=%b product=%h required 0 0 00", busy, done, product);
        end else passed++;
        rst = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (done) dones++;
        end
        total++;
        if (dones !== 0) begin
            $display("FAIL reset_mid_no_done dones=%0d required 0", dones);
        end else passed++;
        run_op(4'd2, 4'd2, lat, bcnt, p);
        total++;
        if (lat !== W + 1 || p !== ref_mul(2, 2)) begin
            $display("FAIL reset_mid_restart lat=%0d product=%h required %0d %h", lat, p, W + 1, ref_mul(2, 2));
        end else passed++;
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; a = '0; b = '0;
        test_reset();
        test_basic();
        test_corners();
        test_busy_protect();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
